// File: rtl/mem_port_arbiter.sv
// Shared single-port memory arbiter between the fetch stage (IF) and the
// memory stage (MEM). Data accesses win by default; a starvation counter
// forces a fetch grant after STARVE_MAX data grants while a fetch waits.
module mem_port_arbiter #(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   // fetch stage
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   input  logic          if_flush,
   output logic [DW-1:0] if_rdata,
   output logic          if_valid,
   output logic          stall_if,
   // memory stage
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic [DW-1:0] dm_rdata,
   output logic          dm_done,
   output logic          stall_mem,
   // memory handshake
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack
);

   localparam int unsigned CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE,
      IBUSY,
      DBUSY
   } state_t;

   state_t        state_q, state_d;
   logic          flush_pend_q, flush_pend_d;
   logic [CW-1:0] starve_q, starve_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_wdata_q, mem_wdata_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic          if_valid_q, if_valid_d;
   logic [DW-1:0] dm_rdata_q, dm_rdata_d;
   logic          dm_done_q, dm_done_d;

   // A requester whose completion pulse is high this cycle is not re-granted.
   logic if_elig, dm_elig, grant_if, grant_dm;
   assign if_elig  = if_req & ~if_valid_q;
   assign dm_elig  = dm_req & ~dm_done_q;
   assign grant_if = if_elig & ((starve_q == STARVE_LIM) | ~dm_elig);
   assign grant_dm = dm_elig & ~grant_if;

   // Next-state, grant and completion logic.
   always_comb begin
      state_d      = state_q;
      flush_pend_d = flush_pend_q;
      starve_d     = starve_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      if_rdata_d   = if_rdata_q;
      if_valid_d   = 1'b0;
      dm_rdata_d   = dm_rdata_q;
      dm_done_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!if_req) begin
               starve_d = '0;
            end
            if (grant_if) begin
               state_d     = IBUSY;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr;
               mem_wdata_d = '0;
               starve_d    = '0;
            end else if (grant_dm) begin
               state_d     = DBUSY;
               mem_req_d   = 1'b1;
               mem_we_d    = dm_we;
               mem_addr_d  = dm_addr;
               mem_wdata_d = dm_wdata;
               if (if_req && (starve_q != STARVE_LIM)) begin
                  starve_d = starve_q + CW'(1);
               end
            end
         end

         IBUSY: begin
            if (mem_ack) begin
               state_d      = IDLE;
               mem_req_d    = 1'b0;
               flush_pend_d = 1'b0;
               if (!flush_pend_q && !if_flush) begin
                  if_rdata_d = mem_rdata;
                  if_valid_d = 1'b1;
               end
            end else if (if_flush) begin
               flush_pend_d = 1'b1;
            end
         end

         DBUSY: begin
            if (mem_ack) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               dm_done_d = 1'b1;
               if (!mem_we_q) begin
                  dm_rdata_d = mem_rdata;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         flush_pend_q <= 1'b0;
         starve_q     <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         if_rdata_q   <= '0;
         if_valid_q   <= 1'b0;
         dm_rdata_q   <= '0;
         dm_done_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         flush_pend_q <= flush_pend_d;
         starve_q     <= starve_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         if_rdata_q   <= if_rdata_d;
         if_valid_q   <= if_valid_d;
         dm_rdata_q   <= dm_rdata_d;
         dm_done_q    <= dm_done_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_rdata  = if_rdata_q;
   assign if_valid  = if_valid_q;
   assign dm_rdata  = dm_rdata_q;
   assign dm_done   = dm_done_q;

   // Stalls are gated by reset so the hazard logic sees no stall while held in reset.
   assign stall_if  = rst_n & if_req & ~if_valid_q;
   assign stall_mem = rst_n & dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios followed by
// concurrent random fetch/data traffic against a behavioural memory model.
module tb_mem_port_arbiter;

   localparam int unsigned STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, if_flush, dm_req, dm_we;
   logic [31:0] if_addr, dm_addr, dm_wdata;
   logic [31:0] if_rdata, dm_rdata;
   logic        if_valid, stall_if, dm_done, stall_mem;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_rdata(if_rdata), .if_valid(if_valid), .stall_if(stall_if),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_done(dm_done), .stall_mem(stall_mem),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic        is_store;
      logic [31:0] val;
   } dm_exp_t;

   logic [31:0] if_q[$];
   dm_exp_t     dm_q[$];

   logic [31:0] phys_mem[logic [31:0]];
   logic [31:0] ref_mem[logic [31:0]];

   int force_lat  = -1;
   int inject_req = 0;
   int grant_cnt  = 0;

   function automatic logic [31:0] hash(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
   endfunction

   function automatic logic [31:0] phys_rd(input logic [31:0] a);
      if (phys_mem.exists(a)) return phys_mem[a];
      return hash(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return hash(a);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", name, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Memory responder: ack after a chosen number of wait cycles, stores land on ack.
   initial begin
      int          wait_left;
      bit          in_txn, stray;
      int          inject_seen;
      logic        t_we;
      logic [31:0] t_addr, t_wdata;
      mem_ack = 1'b0; mem_rdata = '0;
      in_txn = 0; stray = 0; inject_seen = 0; wait_left = 0;
      t_we = 0; t_addr = '0; t_wdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            mem_ack = 1'b0; in_txn = 0; stray = 0;
            inject_seen = inject_req;
            continue;
         end
         if (mem_ack) begin
            mem_ack = 1'b0;
            if (!stray && t_we) phys_mem[t_addr] = t_wdata;
            in_txn = 0; stray = 0;
         end else if (inject_seen != inject_req && !mem_req) begin
            inject_seen = inject_req;
            mem_ack = 1'b1; stray = 1;
            mem_rdata = 32'hBAD0_BAD0;
         end
         if (!mem_ack && mem_req) begin
            if (!in_txn) begin
               in_txn = 1;
               wait_left = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
            end
            if (wait_left == 0) begin
               mem_ack = 1'b1;
               t_we = mem_we; t_addr = mem_addr; t_wdata = mem_wdata;
               mem_rdata = mem_we ? $urandom : phys_rd(mem_addr);
            end else begin
               wait_left--;
            end
         end
      end
   end

   // Monitor: pops expectations on completion pulses and checks bus hold rules.
   initial begin
      logic        p_req, p_ack, p_we;
      logic [31:0] p_addr, p_wdata, exp_dm_rdata, e;
      dm_exp_t     d;
      int          starve_run;
      p_req = 0; p_ack = 0; p_we = 0; p_addr = '0; p_wdata = '0;
      exp_dm_rdata = '0; starve_run = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            p_req = 0; p_ack = 0; exp_dm_rdata = '0; starve_run = 0;
            continue;
         end
         if (if_valid) begin
            chk("if_valid_expected", 32'(if_q.size() != 0), 32'd1);
            if (if_q.size() != 0) begin
               e = if_q.pop_front();
               chk("if_rdata", if_rdata, e);
            end
         end
         if (dm_done) begin
            chk("dm_done_expected", 32'(dm_q.size() != 0), 32'd1);
            if (dm_q.size() != 0) begin
               d = dm_q.pop_front();
               if (!d.is_store) exp_dm_rdata = d.val;
               chk(d.is_store ? "dm_rdata_kept_on_store" : "dm_rdata_load", dm_rdata, exp_dm_rdata);
            end
         end
         if (p_req && !p_ack) begin
            chk("mem_req_hold", 32'(mem_req), 32'd1);
            chk("mem_addr_hold", mem_addr, p_addr);
            chk("mem_we_hold", 32'(mem_we), 32'(p_we));
            chk("mem_wdata_hold", mem_wdata, p_wdata);
         end
         if (mem_req && !p_req) begin
            grant_cnt++;
            if (mem_addr >= 32'h1000) starve_run = 0;
            else if (stall_if) begin
               starve_run++;
               chk("starve_bound", 32'(starve_run <= STARVE_MAX), 32'd1);
            end else starve_run = 0;
         end
         p_req = mem_req; p_ack = mem_ack; p_we = mem_we;
         p_addr = mem_addr; p_wdata = mem_wdata;
      end
   end

   task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wd);
      dm_exp_t d;
      bit      got;
      step();
      dm_we = we; dm_addr = addr; dm_wdata = wd; dm_req = 1'b1;
      d.is_store = we;
      d.val      = we ? 32'h0 : ref_rd(addr);
      if (we) ref_mem[addr] = wd;
      dm_q.push_back(d);
      got = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (dm_done) begin got = 1; break; end
      end
      chk("dm_done_timeout", 32'(got), 32'd1);
      step();
      dm_req = 1'b0;
   endtask

   task automatic do_fetch(input logic [31:0] addr);
      bit got;
      step();
      if_addr = addr; if_req = 1'b1;
      if_q.push_back(hash(addr));
      got = 0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (if_valid) begin got = 1; break; end
      end
      chk("if_valid_timeout", 32'(got), 32'd1);
      step();
      if_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] saved, ia, da;
      int          g0;
      dm_exp_t     d;

      // Reset: outputs low and stalls gated even with requests pending.
      rst_n = 1'b0; if_req = 1'b1; dm_req = 1'b1; if_flush = 1'b0;
      dm_we = 1'b0; if_addr = 32'h1000; dm_addr = '0; dm_wdata = '0;
      repeat (2) step();
      @(negedge clk);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_stall_if", 32'(stall_if), 32'd0);
      chk("rst_stall_mem", 32'(stall_mem), 32'd0);
      chk("rst_if_valid", 32'(if_valid), 32'd0);
      chk("rst_dm_done", 32'(dm_done), 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_dm_rdata", dm_rdata, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      step();
      if_req = 1'b0; dm_req = 1'b0; rst_n = 1'b1;
      step();

      // Zero-wait load: grant, one mem_req cycle with ack, then the pulse.
      force_lat = 0;
      phys_mem[32'h40] = 32'hDEAD_BEEF;
      ref_mem[32'h40]  = 32'hDEAD_BEEF;
      for (int c = 0; c < 4; c++) begin
         step();
         if (c == 0) begin
            dm_we = 1'b0; dm_addr = 32'h40; dm_req = 1'b1;
            d.is_store = 1'b0; d.val = 32'hDEAD_BEEF;
            dm_q.push_back(d);
         end
         if (c == 3) dm_req = 1'b0;
         @(negedge clk);
         chk($sformatf("zw_mem_req_c%0d", c), 32'(mem_req), 32'(c == 1));
         chk($sformatf("zw_dm_done_c%0d", c), 32'(dm_done), 32'(c == 2));
         chk($sformatf("zw_stall_mem_c%0d", c), 32'(stall_mem), 32'(c < 2));
         if (c == 2) chk("zw_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
      end

      // Priority: store wins over a simultaneous fetch, fetch follows in the pulse cycle.
      force_lat = 2;
      for (int c = 0; c < 10; c++) begin
         step();
         if (c == 0) begin
            if_addr = 32'h1010; if_req = 1'b1;
            dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h11; dm_req = 1'b1;
            if_q.push_back(hash(32'h1010));
            ref_mem[32'h80] = 32'h11;
            d.is_store = 1'b1; d.val = 32'h0;
            dm_q.push_back(d);
         end
         if (c == 5) dm_req = 1'b0;
         if (c == 9) if_req = 1'b0;
         @(negedge clk);
         if (c == 1) begin
            chk("prio_first_we", 32'(mem_we), 32'd1);
            chk("prio_first_addr", mem_addr, 32'h80);
            chk("prio_first_wdata", mem_wdata, 32'h11);
         end
         if (c == 5) begin
            chk("prio_second_req", 32'(mem_req), 32'd1);
            chk("prio_second_we", 32'(mem_we), 32'd0);
            chk("prio_second_addr", mem_addr, 32'h1010);
         end
         chk($sformatf("prio_dm_done_c%0d", c), 32'(dm_done), 32'(c == 4));
         chk($sformatf("prio_if_valid_c%0d", c), 32'(if_valid), 32'(c == 8));
         chk($sformatf("prio_stall_if_c%0d", c), 32'(stall_if), 32'(c < 8));
      end

      // Flush while the fetch is in flight: no pulse, if_rdata untouched.
      force_lat = 3;
      saved = hash(32'h1010);
      for (int c = 0; c < 7; c++) begin
         step();
         if (c == 0) begin if_addr = 32'h1020; if_req = 1'b1; end
         if (c == 2) if_flush = 1'b1;
         if (c == 3) if_flush = 1'b0;
         if (c == 5) if_req = 1'b0;
         @(negedge clk);
         chk($sformatf("flush_if_valid_c%0d", c), 32'(if_valid), 32'd0);
         if (c == 4) chk("flush_mem_req_c4", 32'(mem_req), 32'd1);
         if (c == 5) chk("flush_mem_req_c5", 32'(mem_req), 32'd0);
      end
      chk("flush_if_rdata_kept", if_rdata, saved);
      force_lat = 1;
      do_fetch(32'h1030);

      // Asynchronous reset in the middle of a data access, then a stray ack.
      force_lat = 6;
      step();
      dm_we = 1'b0; dm_addr = 32'h44; dm_req = 1'b1;
      repeat (3) step();
      #1;
      chk("arst_busy_before", 32'(mem_req), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_mem_req", 32'(mem_req), 32'd0);
      chk("arst_dm_done", 32'(dm_done), 32'd0);
      chk("arst_stall_mem", 32'(stall_mem), 32'd0);
      dm_req = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
      inject_req++;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("stray_mem_req_c%0d", c), 32'(mem_req), 32'd0);
         chk($sformatf("stray_dm_done_c%0d", c), 32'(dm_done), 32'd0);
         chk($sformatf("stray_if_valid_c%0d", c), 32'(if_valid), 32'd0);
         step();
      end
      force_lat = 0;
      do_data(1'b0, 32'h48, 32'h0);

      // No re-grant: request held through its done cycle yields one transaction.
      g0 = grant_cnt;
      do_data(1'b0, 32'h40, 32'h0);
      repeat (3) step();
      chk("no_regrant_count", 32'(grant_cnt - g0), 32'd1);

      // Concurrent random traffic from both stages.
      force_lat = -1;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               repeat ($urandom_range(0, 2)) step();
               da = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
               do_data(1'($urandom_range(0, 1)), da, $urandom);
            end
         end
         begin
            for (int i = 0; i < 40; i++) begin
               repeat ($urandom_range(0, 2)) step();
               ia = 32'h1000 | {22'h0, 8'($urandom_range(0, 255)), 2'b00};
               do_fetch(ia);
            end
         end
      join
      repeat (5) step();
      chk("if_queue_drained", 32'(if_q.size()), 32'd0);
      chk("dm_queue_drained", 32'(dm_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
